otbn_mac_bignum_mul256_seq: RTL
===============================

// Module: otbn_mac_bignum_mul256_seq
//
// PURPOSE
// Sequencer that drives the bignum MAC through the fixed 16-step MULQACC schedule to form a full
// 256x256 -> 512-bit product without core instruction issue. Sits beside the MAC; an external
// mux selects the core's MAC controls when mac_en_o is low. Latches operands, issues one op per
// cycle, collects the four shifted-out half-words and reports done/error.
//
// PARAMETERS
// StallLimit  64  max consecutive stall cycles in RUN before err; 0 disables the watchdog
// ZeroOnErr   1   1: result_o cleared on error; 0: partial result retained
//
// PORTS
// clk_i                  in   1        clock
// rst_ni                 in   1        async active-low reset
// start_i                in   1        start request, sampled in IDLE only
// operand_a_i            in   WLEN     multiplicand, latched on accepted start
// operand_b_i            in   WLEN     multiplier, latched on accepted start
// core_mac_req_i         in   1        core owns the MAC this cycle; sequencer stalls
// sec_wipe_i             in   1        abort, clear all state
// busy_o                 out  1        high in RUN
// done_o                 out  1        1-cycle pulse at completion (also on error)
// err_o                  out  1        1-cycle pulse with done_o on error
// result_o               out  2*WLEN   product {hw3,hw2,hw1,hw0}
// mac_en_o               out  1        MAC op valid; mac_commit_o equals mac_en_o
// mac_commit_o           out  1        MAC accumulator commit
// mac_operand_a_o        out  WLEN     latched operand A
// mac_operand_b_o        out  WLEN     latched operand B
// mac_a_qw_sel_o         out  2        operand_a_qw_sel
// mac_b_qw_sel_o         out  2        operand_b_qw_sel
// mac_shift_imm_o        out  2        pre_acc_shift_imm (0 or 1 = 64 bits)
// mac_zero_acc_o         out  1        zero_acc
// mac_shift_acc_o        out  1        shift_acc (.SO)
// mac_wr_hw_upper_o      out  1        wr_hw_sel_upper
// mac_predec_op_en_o     out  1        predecode op_en (== mac_en_o)
// mac_predec_acc_rd_en_o out  1        predecode acc_rd_en (mac_en_o & ~mac_zero_acc_o)
// mac_result_i           in   WLEN     MAC operation_result_o
// mac_intg_err_i         in   1        MAC operation_intg_violation_err_o
// mac_predec_err_i       in   1        MAC predec_error_o
//
// BEHAVIOUR
// - Reset: state IDLE, step=0, stall_cnt=0; all outputs 0; operand and result regs 0.
// - FSM IDLE -> RUN on start_i; latch operands, clear result_o. start_i in RUN/DONE ignored.
// - RUN: if core_mac_req_i: mac_en_o=0, step held, stall_cnt++. Else mac_en_o=1, step++, stall_cnt=0.
// - Step table (a_qw,b_qw,shift; Z=zero_acc, SO=shift_acc, capture mac_result_i[127:0]):
//   0:0,0,0 Z | 1:1,0,1 | 2:0,1,1 SO->hw0 | 3:2,0,0 | 4:1,1,0 | 5:0,2,0 | 6:3,0,1 | 7:2,1,1
//   8:1,2,1 | 9:0,3,1 SO,upper->hw1 | 10:3,1,0 | 11:2,2,0 | 12:1,3,0 | 13:3,2,1
//   14:2,3,1 SO->hw2 | 15:3,3,0 SO,upper->hw3. Fields not listed are 0; all fields 0 when mac_en_o=0.
// - Capture into result reg on the clock edge ending the issuing cycle.
// - RUN -> DONE after step 15 issues; DONE lasts 1 cycle: done_o=1, busy_o=0; DONE -> IDLE.
// - No stalls: start accepted at edge 0, ops cycles 1..16, done_o in cycle 17.
// - Error: mac_intg_err_i or mac_predec_err_i while mac_en_o=1 -> DONE with err_o=1; the failing
//   op's capture is suppressed; result cleared if ZeroOnErr. Inputs ignored when mac_en_o=0.
// - Watchdog: stall_cnt reaching StallLimit (nonzero) -> DONE with err_o=1.
// - sec_wipe_i (any state, wins over all) -> IDLE next cycle; operand/result regs cleared; no done_o.
// - result_o holds until the next accepted start, error clear or wipe.
// - Async reset mid-operation: immediate return to reset values; MAC acc contents undefined.
//
// TESTING
// - a=1,b=1, start -> mac_en_o high cycles 1..16, done_o cycle 17, result_o=1, err_o=0.
// - a=b=2^256-1 -> result_o=2^512-2^257+1; hw3 captured at step 15.
// - a=2^192,b=2^192, core_mac_req_i high 3 cycles at step 5 -> done_o cycle 20, result_o=2^384.
// - mac_intg_err_i pulsed at step 7 -> err_o+done_o next cycle, result_o=0, no further mac_en_o.
// - core_mac_req_i held high from step 4, StallLimit=64 -> err_o after 64 stall cycles.
// - sec_wipe_i at step 10 -> busy_o=0 next cycle, result_o=0, done_o never asserts; restart ok.

Source files
------------

// File: rtl/otbn_mac_bignum_mul256_seq_if.sv
// Bus between the 256x256 multiply sequencer and the bignum MAC.
// The master side (sequencer) drives op controls; the slave side (MAC) returns results.
interface otbn_mac_bignum_mul256_seq_if #(
    parameter int WLEN = 256
);
    logic            mac_en_o;
    logic            mac_commit_o;
    logic [WLEN-1:0] mac_operand_a_o;
    logic [WLEN-1:0] mac_operand_b_o;
    logic [1:0]      mac_a_qw_sel_o;
    logic [1:0]      mac_b_qw_sel_o;
    logic [1:0]      mac_shift_imm_o;
    logic            mac_zero_acc_o;
    logic            mac_shift_acc_o;
    logic            mac_wr_hw_upper_o;
    logic            mac_predec_op_en_o;
    logic            mac_predec_acc_rd_en_o;
    logic [WLEN-1:0] mac_result_i;
    logic            mac_intg_err_i;
    logic            mac_predec_err_i;

    modport master (
        output mac_en_o, mac_commit_o, mac_operand_a_o, mac_operand_b_o,
        output mac_a_qw_sel_o, mac_b_qw_sel_o, mac_shift_imm_o,
        output mac_zero_acc_o, mac_shift_acc_o, mac_wr_hw_upper_o,
        output mac_predec_op_en_o, mac_predec_acc_rd_en_o,
        input  mac_result_i, mac_intg_err_i, mac_predec_err_i
    );

    modport slave (
        input  mac_en_o, mac_commit_o, mac_operand_a_o, mac_operand_b_o,
        input  mac_a_qw_sel_o, mac_b_qw_sel_o, mac_shift_imm_o,
        input  mac_zero_acc_o, mac_shift_acc_o, mac_wr_hw_upper_o,
        input  mac_predec_op_en_o, mac_predec_acc_rd_en_o,
        output mac_result_i, mac_intg_err_i, mac_predec_err_i
    );
endinterface

// File: rtl/otbn_mac_bignum_mul256_seq.sv
// Drives the bignum MAC through the 16-step MULQACC schedule to form a
// 256x256 -> 512-bit product, collecting four 128-bit half-words.
module otbn_mac_bignum_mul256_seq #(
    parameter int WLEN       = 256,
    parameter int StallLimit = 64,
    parameter bit ZeroOnErr  = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [WLEN-1:0]      operand_a_i,
    input  logic [WLEN-1:0]      operand_b_i,
    input  logic                 core_mac_req_i,
    input  logic                 sec_wipe_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [2*WLEN-1:0]    result_o,
    otbn_mac_bignum_mul256_seq_if.master mac
);
    localparam int SW = $clog2(StallLimit + 2);
    localparam int HW = WLEN / 2;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e            r_state, w_state_nxt;
    logic [3:0]        r_step, w_step_nxt;
    logic [SW-1:0]     r_stall, w_stall_nxt, w_stall_inc;
    logic              r_err, w_err_nxt;
    logic [WLEN-1:0]   r_op_a, r_op_b;
    logic [2*WLEN-1:0] r_result;

    logic       w_issue, w_fault, w_wdog, w_go_err;
    logic [1:0] w_a_sel, w_b_sel, w_shift, w_hw;
    logic       w_zero, w_so, w_upper;
    logic       w_unused_res;

    assign w_unused_res = ^mac.mac_result_i[WLEN-1:HW];

    assign w_issue     = (r_state == RUN) & ~core_mac_req_i & ~sec_wipe_i;
    assign w_fault     = w_issue & (mac.mac_intg_err_i | mac.mac_predec_err_i);
    assign w_stall_inc = r_stall + SW'(1);
    assign w_wdog      = (StallLimit != 0) & (r_state == RUN) & core_mac_req_i
                       & (w_stall_inc >= SW'(StallLimit));
    assign w_go_err    = w_fault | w_wdog;

    // MULQACC schedule: quad-word selects, pre-shift and accumulator control per step
    always_comb begin
        w_a_sel = 2'd0;
        w_b_sel = 2'd0;
        w_shift = 2'd0;
        w_zero  = 1'b0;
        w_so    = 1'b0;
        w_upper = 1'b0;
        w_hw    = 2'd0;
        unique case (r_step)
            4'd0:  w_zero = 1'b1;
            4'd1:  begin w_a_sel = 2'd1; w_shift = 2'd1; end
            4'd2:  begin w_b_sel = 2'd1; w_shift = 2'd1; w_so = 1'b1; w_hw = 2'd0; end
            4'd3:  w_a_sel = 2'd2;
            4'd4:  begin w_a_sel = 2'd1; w_b_sel = 2'd1; end
            4'd5:  w_b_sel = 2'd2;
            4'd6:  begin w_a_sel = 2'd3; w_shift = 2'd1; end
            4'd7:  begin w_a_sel = 2'd2; w_b_sel = 2'd1; w_shift = 2'd1; end
            4'd8:  begin w_a_sel = 2'd1; w_b_sel = 2'd2; w_shift = 2'd1; end
            4'd9:  begin
                w_b_sel = 2'd3; w_shift = 2'd1;
                w_so = 1'b1; w_upper = 1'b1; w_hw = 2'd1;
            end
            4'd10: begin w_a_sel = 2'd3; w_b_sel = 2'd1; end
            4'd11: begin w_a_sel = 2'd2; w_b_sel = 2'd2; end
            4'd12: begin w_a_sel = 2'd1; w_b_sel = 2'd3; end
            4'd13: begin w_a_sel = 2'd3; w_b_sel = 2'd2; w_shift = 2'd1; end
            4'd14: begin
                w_a_sel = 2'd2; w_b_sel = 2'd3; w_shift = 2'd1;
                w_so = 1'b1; w_hw = 2'd2;
            end
            4'd15: begin
                w_a_sel = 2'd3; w_b_sel = 2'd3;
                w_so = 1'b1; w_upper = 1'b1; w_hw = 2'd3;
            end
            default: ;
        endcase
    end

    // Next state: step advance, stall counting, error/watchdog exit, wipe override
    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_stall_nxt = r_stall;
        w_err_nxt   = r_err;
        unique case (r_state)
            IDLE: begin
                w_err_nxt = 1'b0;
                if (start_i) begin
                    w_state_nxt = RUN;
                    w_step_nxt  = 4'd0;
                    w_stall_nxt = '0;
                end
            end
            RUN: begin
                if (core_mac_req_i) begin
                    w_stall_nxt = w_stall_inc;
                    if (w_wdog) begin
                        w_state_nxt = DONE;
                        w_err_nxt   = 1'b1;
                    end
                end else if (w_fault) begin
                    w_state_nxt = DONE;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_step_nxt  = r_step + 4'd1;
                    w_stall_nxt = '0;
                    if (r_step == 4'd15) begin
                        w_state_nxt = DONE;
                        w_err_nxt   = 1'b0;
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
                w_step_nxt  = 4'd0;
                w_stall_nxt = '0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_step_nxt  = 4'd0;
                w_stall_nxt = '0;
                w_err_nxt   = 1'b0;
            end
        endcase
        if (sec_wipe_i) begin
            w_state_nxt = IDLE;
            w_step_nxt  = 4'd0;
            w_stall_nxt = '0;
            w_err_nxt   = 1'b0;
        end
    end

    // Control state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_step  <= 4'd0;
            r_stall <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
            r_stall <= w_stall_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Operand latch and half-word capture; a faulting op never lands in the result
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_result <= '0;
        end else if (sec_wipe_i) begin
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_result <= '0;
        end else if (r_state == IDLE && start_i) begin
            r_op_a   <= operand_a_i;
            r_op_b   <= operand_b_i;
            r_result <= '0;
        end else if (w_go_err) begin
            if (ZeroOnErr) r_result <= '0;
        end else if (w_issue && w_so) begin
            r_result[w_hw*HW +: HW] <= mac.mac_result_i[HW-1:0];
        end
    end

    assign busy_o   = (r_state == RUN);
    assign done_o   = (r_state == DONE);
    assign err_o    = (r_state == DONE) & r_err;
    assign result_o = r_result;

    assign mac.mac_en_o               = w_issue;
    assign mac.mac_commit_o           = w_issue;
    assign mac.mac_predec_op_en_o     = w_issue;
    assign mac.mac_operand_a_o        = r_op_a;
    assign mac.mac_operand_b_o        = r_op_b;
    assign mac.mac_a_qw_sel_o         = w_issue ? w_a_sel : 2'd0;
    assign mac.mac_b_qw_sel_o         = w_issue ? w_b_sel : 2'd0;
    assign mac.mac_shift_imm_o        = w_issue ? w_shift : 2'd0;
    assign mac.mac_zero_acc_o         = w_issue & w_zero;
    assign mac.mac_shift_acc_o        = w_issue & w_so;
    assign mac.mac_wr_hw_upper_o      = w_issue & w_upper;
    assign mac.mac_predec_acc_rd_en_o = w_issue & ~w_zero;
endmodule
